alu_out_wb: RTL and testbench

//  Return path of the GF(2^163) ALU datapath. Accepts ALU results over a valid/ready

---
 rtl/ecc_pkg.sv | 40 ++++
 rtl/ecc_wb_scoreboard.sv | 44 ++++
 rtl/alu_out_wb.sv | 193 +++++++++++++++++++
 tb/tb_alu_out_wb.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared types and constants for the GF(2^163) ALU writeback path.
package ecc_pkg;

  localparam int unsigned W      = 163;
  localparam int unsigned NDEST  = 5;
  localparam int unsigned DEST_W = 3;

  localparam logic [DEST_W-1:0] DEST_XA = 3'd0;
  localparam logic [DEST_W-1:0] DEST_XB = 3'd1;
  localparam logic [DEST_W-1:0] DEST_ZA = 3'd2;
  localparam logic [DEST_W-1:0] DEST_ZB = 3'd3;
  localparam logic [DEST_W-1:0] DEST_ZC = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [W-1:0]      data;
  } wb_beat_t;

  // One-hot scoreboard mask {ZC,ZB,ZA,XB,XA}; illegal codes map to zero
  function automatic logic [NDEST-1:0] dest_mask(input logic [DEST_W-1:0] dest);
    logic [NDEST-1:0] mask;
    mask = '0;
    case (dest)
      DEST_XA: mask = 5'b00001;
      DEST_XB: mask = 5'b00010;
      DEST_ZA: mask = 5'b00100;
      DEST_ZB: mask = 5'b01000;
      DEST_ZC: mask = 5'b10000;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ecc_wb_scoreboard.sv
// Pending-write scoreboard: one bit per operand register, set on issue and
// cleared on writeback, with hazard detection feeding the sticky error flag.
module ecc_wb_scoreboard
  import ecc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              active,
  input  logic              iss_valid,
  input  logic [DEST_W-1:0] iss_dest,
  input  logic              wb_fire,
  input  logic [DEST_W-1:0] wb_dest,
  output logic [NDEST-1:0]  pending,
  output logic              hazard_err_c
);

  logic [NDEST-1:0] iss_mask;
  logic [NDEST-1:0] wb_mask;
  logic             iss_blocked;
  logic [NDEST-1:0] pending_nxt;

  // Issue is legal only in ACTIVE to a legal dest that is free or retiring this edge
  always_comb begin
    iss_mask     = dest_mask(iss_dest);
    wb_mask      = wb_fire ? dest_mask(wb_dest) : '0;
    iss_blocked  = !active || (iss_mask == '0) || ((pending & iss_mask & ~wb_mask) != '0);
    hazard_err_c = (iss_valid && iss_blocked) ||
                   (wb_fire && ((wb_mask == '0) || ((pending & wb_mask) == '0)));
    pending_nxt  = (pending & ~wb_mask) | ((iss_valid && !iss_blocked) ? iss_mask : '0);
  end

  // Scoreboard register, wiped by a ladder init
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (clear) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/alu_out_wb.sv
// Return path of the GF(2^163) ALU: accepts results and writes the ladder
// operand registers, with ladder swap, pending scoreboard and writeback count.
// Optional feature macro: ECC_WB_PARITY_EN (per-register even parity checking).
module alu_out_wb
  import ecc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_valid,
  input  logic [W-1:0]      init_x,
  input  logic              iss_valid,
  input  logic [DEST_W-1:0] iss_dest,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [DEST_W-1:0] wb_dest,
  input  logic [W-1:0]      wb_data,
  input  logic              swap_req,
  output logic              swap_ack,
  input  logic              finish_req,
  output logic              done,
  output logic [W-1:0]      xa,
  output logic [W-1:0]      xb,
  output logic [W-1:0]      za,
  output logic [W-1:0]      zb,
  output logic [W-1:0]      zc,
  output logic [NDEST-1:0]  pending,
  output logic [CNT_W-1:0]  wb_count,
  output logic              err
);

  state_t   state;
  state_t   state_nxt;
  wb_beat_t beat;
  logic     wb_fire;
  logic     init_fire;
  logic     active;
  logic     drain_done;
  logic     init_err;
  logic     sb_err_c;
  logic     parity_err_c;

  assign beat    = '{dest: wb_dest, data: wb_data};
  assign wb_fire = wb_valid && wb_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: IDLE -> ACTIVE on init, ACTIVE -> DRAIN on finish, DRAIN -> IDLE when empty
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (init_valid) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (finish_req) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (pending == '0) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Per-state handshake, swap grant and event decode
  always_comb begin
    wb_ready   = 1'b0;
    swap_ack   = 1'b0;
    init_fire  = 1'b0;
    active     = 1'b0;
    drain_done = 1'b0;
    init_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        init_fire = init_valid;
      end
      ST_ACTIVE: begin
        active   = 1'b1;
        swap_ack = swap_req && (pending[3:0] == 4'b0000);
        wb_ready = !swap_ack;
        init_err = init_valid;
      end
      ST_DRAIN: begin
        wb_ready   = 1'b1;
        drain_done = (pending == '0);
        init_err   = init_valid;
      end
      default: ;
    endcase
  end

  ecc_wb_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (init_fire),
    .active       (active),
    .iss_valid    (iss_valid),
    .iss_dest     (iss_dest),
    .wb_fire      (wb_fire),
    .wb_dest      (beat.dest),
    .pending      (pending),
    .hazard_err_c (sb_err_c)
  );

  // Operand registers: init load, ladder swap, or accepted writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xa <= '0;
      xb <= '0;
      za <= '0;
      zb <= '0;
      zc <= '0;
    end else if (init_fire) begin
      xa <= init_x;
      xb <= '0;
      za <= W'(1);
      zb <= '0;
      zc <= '0;
    end else if (swap_ack) begin
      xa <= xb;
      xb <= xa;
      za <= zb;
      zb <= za;
    end else if (wb_fire) begin
      case (beat.dest)
        DEST_XA: xa <= beat.data;
        DEST_XB: xb <= beat.data;
        DEST_ZA: za <= beat.data;
        DEST_ZB: zb <= beat.data;
        DEST_ZC: zc <= beat.data;
        default: ;
      endcase
    end
  end

`ifdef ECC_WB_PARITY_EN
  logic [NDEST-1:0] par;

  // Even parity bit per register {ZC,ZB,ZA,XB,XA}, follows every register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= '0;
    end else if (init_fire) begin
      par <= {1'b0, 1'b0, 1'b1, 1'b0, ^init_x};
    end else if (swap_ack) begin
      par <= {par[4], par[2], par[3], par[0], par[1]};
    end else if (wb_fire) begin
      case (beat.dest)
        DEST_XA: par[0] <= ^beat.data;
        DEST_XB: par[1] <= ^beat.data;
        DEST_ZA: par[2] <= ^beat.data;
        DEST_ZB: par[3] <= ^beat.data;
        DEST_ZC: par[4] <= ^beat.data;
        default: ;
      endcase
    end
  end

  assign parity_err_c = ((^xa) != par[0]) || ((^xb) != par[1]) || ((^za) != par[2]) ||
                        ((^zb) != par[3]) || ((^zc) != par[4]);
`else
  assign parity_err_c = 1'b0;
`endif

  // Saturating writeback counter, restarted by init
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count <= '0;
    end else if (init_fire) begin
      wb_count <= '0;
    end else if (wb_fire && (wb_count != '1)) begin
      wb_count <= wb_count + CNT_W'(1);
    end
  end

  // Sticky error flag and drain-complete pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= drain_done;
      if (init_fire) begin
        err <= 1'b0;
      end else if (sb_err_c || init_err || parity_err_c) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_out_wb.sv
// Self-checking bench for alu_out_wb: directed ladder scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_alu_out_wb;
  import ecc_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic              clk;
  logic              rst_n;
  logic              init_valid;
  logic [W-1:0]      init_x;
  logic              iss_valid;
  logic [DEST_W-1:0] iss_dest;
  logic              wb_valid;
  logic              wb_ready;
  logic [DEST_W-1:0] wb_dest;
  logic [W-1:0]      wb_data;
  logic              swap_req;
  logic              swap_ack;
  logic              finish_req;
  logic              done;
  logic [W-1:0]      xa, xb, za, zb, zc;
  logic [NDEST-1:0]  pending;
  logic [CNT_W-1:0]  wb_count;
  logic              err;

  int total = 0;
  int bad   = 0;

  // Behavioural model: registers as an array indexed by dest code, 0=idle 1=active 2=drain
  logic [W-1:0] m_reg [5];
  logic [4:0]   m_pend;
  int unsigned  m_cnt;
  logic         m_err;
  logic         m_done;
  int           m_st;

  alu_out_wb #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_valid (init_valid),
    .init_x     (init_x),
    .iss_valid  (iss_valid),
    .iss_dest   (iss_dest),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .finish_req (finish_req),
    .done       (done),
    .xa         (xa),
    .xb         (xb),
    .za         (za),
    .zb         (zb),
    .zc         (zc),
    .pending    (pending),
    .wb_count   (wb_count),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = '0;
    m_pend = '0;
    m_cnt  = 0;
    m_err  = 1'b0;
    m_done = 1'b0;
    m_st   = 0;
  endtask

  function automatic logic m_swap();
    return swap_req && (m_st == 1) && (m_pend[3:0] == 4'b0000);
  endfunction

  function automatic logic m_ready();
    return (m_st != 0) && !m_swap();
  endfunction

  // Advance the model across one clock edge using the inputs currently driven
  task automatic model_edge();
    logic       sw;
    logic       fire;
    logic [4:0] p0;
    logic [W-1:0] t;
    int         wd;
    int         id;
    sw   = m_swap();
    fire = wb_valid && m_ready();
    p0   = m_pend;
    wd   = int'(wb_dest);
    id   = int'(iss_dest);
    m_done = 1'b0;
    if (m_st == 0) begin
      if (init_valid) begin
        m_reg[0] = init_x;
        m_reg[1] = '0;
        m_reg[2] = W'(1);
        m_reg[3] = '0;
        m_reg[4] = '0;
        m_pend   = '0;
        m_cnt    = 0;
        m_err    = 1'b0;
        m_st     = 1;
      end else if (iss_valid) begin
        m_err = 1'b1;
      end
      return;
    end
    if (init_valid) m_err = 1'b1;
    if (sw) begin
      t = m_reg[0]; m_reg[0] = m_reg[1]; m_reg[1] = t;
      t = m_reg[2]; m_reg[2] = m_reg[3]; m_reg[3] = t;
    end
    if (fire) begin
      if (m_cnt < 65535) m_cnt++;
      if (wd < 5) begin
        if (!p0[wd]) m_err = 1'b1;
        m_reg[wd]  = wb_data;
        m_pend[wd] = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (iss_valid) begin
      if (m_st != 1 || id >= 5) m_err = 1'b1;
      else if (p0[id] && !(fire && wd == id)) m_err = 1'b1;
      else m_pend[id] = 1'b1;
    end
    if (m_st == 2 && p0 == 5'b0) begin
      m_st   = 0;
      m_done = 1'b1;
    end else if (m_st == 1 && finish_req) begin
      m_st = 2;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".xa"}, xa, m_reg[0]);
    chk({tag, ".xb"}, xb, m_reg[1]);
    chk({tag, ".za"}, za, m_reg[2]);
    chk({tag, ".zb"}, zb, m_reg[3]);
    chk({tag, ".zc"}, zc, m_reg[4]);
    chk({tag, ".pending"}, W'(pending), W'(m_pend));
    chk({tag, ".wb_count"}, W'(wb_count), W'(m_cnt));
    chk({tag, ".err"}, W'(err), W'(m_err));
    chk({tag, ".done"}, W'(done), W'(m_done));
  endtask

  // One clock: check handshake outputs, advance model, check registered outputs
  task automatic step(input string tag);
    #1;
    chk({tag, ".wb_ready"}, W'(wb_ready), W'(m_ready()));
    chk({tag, ".swap_ack"}, W'(swap_ack), W'(m_swap()));
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    init_valid = 1'b0;
    iss_valid  = 1'b0;
    wb_valid   = 1'b0;
    swap_req   = 1'b0;
    finish_req = 1'b0;
  endtask

  initial begin
    logic [W-1:0] x0;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    x0 = {41{4'h5, 4'hA}} >> 1;
    x0 = W'(128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A);
    d1 = rnd_w();
    d2 = rnd_w();
    rst_n   = 1'b0;
    init_x  = '0;
    iss_dest = '0;
    wb_dest = '0;
    wb_data = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.wb_ready", W'(wb_ready), W'(0));
    rst_n = 1'b1;

    // Ladder init
    init_valid = 1'b1; init_x = x0;
    step("init");
    init_valid = 1'b0;
    chk("init.xa_const", xa, x0);
    chk("init.za_const", za, W'(1));
    chk("init.active", W'(wb_ready), W'(1));

    // Issue then write ZA
    iss_valid = 1'b1; iss_dest = DEST_ZA;
    step("iss_za");
    iss_valid = 1'b0;
    chk("iss_za.pending_const", W'(pending), W'(5'b00100));
    wb_valid = 1'b1; wb_dest = DEST_ZA; wb_data = W'(16'h1234);
    step("wb_za");
    wb_valid = 1'b0;
    chk("wb_za.za_const", za, W'(16'h1234));
    chk("wb_za.count_const", W'(wb_count), W'(1));

    // Swap blocked by a pending XB write, then granted once it retires
    iss_valid = 1'b1; iss_dest = DEST_XB;
    step("iss_xb");
    iss_valid = 1'b0;
    swap_req = 1'b1;
    #1;
    chk("swap_blocked", W'(swap_ack), W'(0));
    step("swap_blocked");
    swap_req = 1'b0;
    wb_valid = 1'b1; wb_dest = DEST_XB; wb_data = d1;
    step("wb_xb");
    wb_valid = 1'b0;
    swap_req = 1'b1;
    #1;
    chk("swap_granted", W'(swap_ack), W'(1));
    step("swap");
    swap_req = 1'b0;
    chk("swap.xa_const", xa, d1);
    chk("swap.xb_const", xb, x0);
    chk("swap.zb_const", zb, W'(16'h1234));
    chk("swap.za_const", za, W'(0));

    // Writeback held off by a simultaneous swap, accepted next cycle
    iss_valid = 1'b1; iss_dest = DEST_ZC;
    step("iss_zc");
    iss_valid = 1'b0;
    swap_req = 1'b1; wb_valid = 1'b1; wb_dest = DEST_ZC; wb_data = d2;
    #1;
    chk("held.wb_ready", W'(wb_ready), W'(0));
    step("held");
    swap_req = 1'b0;
    chk("held.zc_const", zc, W'(0));
    step("held_accept");
    wb_valid = 1'b0;
    chk("held_accept.zc_const", zc, d2);

    // Illegal destination, then a hazardous issue
    wb_valid = 1'b1; wb_dest = 3'd6; wb_data = rnd_w();
    step("illegal_wb");
    wb_valid = 1'b0;
    chk("illegal_wb.err_const", W'(err), W'(1));
    iss_valid = 1'b1; iss_dest = DEST_XA;
    step("iss_xa");
    step("iss_xa_again");
    iss_dest = DEST_ZB;
    step("iss_zb");
    iss_valid = 1'b0;
    chk("hazard.err_const", W'(err), W'(1));

    // Drain with two outstanding writes
    finish_req = 1'b1;
    step("finish");
    finish_req = 1'b0;
    wb_valid = 1'b1; wb_dest = DEST_XA; wb_data = rnd_w();
    step("drain_wb0");
    wb_dest = DEST_ZB; wb_data = rnd_w();
    step("drain_wb1");
    wb_valid = 1'b0;
    chk("drain.done_low", W'(done), W'(0));
    step("drain_exit");
    chk("drain_exit.done_const", W'(done), W'(1));
    chk("drain_exit.idle", W'(wb_ready), W'(0));
    step("after_done");
    chk("after_done.done_const", W'(done), W'(0));

    // Async reset in the middle of a drain
    init_valid = 1'b1; init_x = rnd_w();
    step("reinit");
    init_valid = 1'b0;
    chk("reinit.err_clear", W'(err), W'(0));
    iss_valid = 1'b1; iss_dest = DEST_XB;
    step("reinit_iss");
    iss_valid = 1'b0;
    finish_req = 1'b1;
    step("reinit_finish");
    finish_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    chk("mid_reset.wb_ready", W'(wb_ready), W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      init_valid = (m_st == 0) ? 1'b1 : ($urandom_range(0, 49) == 0);
      init_x     = rnd_w();
      iss_valid  = ($urandom_range(0, 2) == 0);
      iss_dest   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      wb_valid   = ($urandom_range(0, 1) == 0);
      wb_dest    = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      wb_data    = rnd_w();
      swap_req   = ($urandom_range(0, 3) == 0);
      finish_req = ($urandom_range(0, 24) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
